// File: rtl/gsim_row_fetch.sv
// gsim_row_fetch -- matrix-row prefetch stage feeding the Gauss-Seidel core.
//
// Issues a burst of row reads to the 256-bit matrix memory, limits reads in
// flight plus buffered rows to DEPTH (credit rule), buffers returned rows in
// a small FIFO tagged with their burst offset, and hands them to the solver
// over valid/ready.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start                 launch pulse (ignored while o_busy)
//   i_base_addr, i_len      burst base row and row count, sampled on i_start
//   o_busy, o_done          burst in progress / one-cycle completion pulse
//   o_mem_rreq, o_mem_addr  registered read request and address
//   i_mem_rrdy              memory accepts the request this cycle
//   i_mem_dout, _vld        returned row, in request order
//   o_row_vld/_data/_idx    row to solver with its offset in the burst
//   i_row_rdy               solver consumes the row
//   o_err                   sticky: row returned with no read outstanding
//
// Build option: define GSIM_FETCH_BYPASS_EN to present a returning row
// combinationally when the FIFO is empty (zero added latency).
module gsim_row_fetch #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rreq,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_rrdy,
  input  logic [DATA_W-1:0] i_mem_dout,
  input  logic              i_mem_dout_vld,
  output logic              o_row_vld,
  output logic [DATA_W-1:0] o_row_data,
  output logic [ADDR_W-1:0] o_row_idx,
  input  logic              i_row_rdy,
  output logic              o_err
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] req_cnt_q, req_cnt_d;
  logic [ADDR_W-1:0] cons_cnt_q, cons_cnt_d;
  logic [ADDR_W-1:0] ret_cnt_q, ret_cnt_d;
  logic [PW:0]       outst_q, outst_d;
  logic [PW:0]       wr_ptr_q, wr_ptr_d;
  logic [PW:0]       rd_ptr_q, rd_ptr_d;
  logic [PW:0]       occ_d;
  logic [PW+1:0]     credit_used;
  logic              rreq_q, rreq_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_d [DEPTH];
  logic [ADDR_W-1:0] fifo_idx_q  [DEPTH];
  logic [ADDR_W-1:0] fifo_idx_d  [DEPTH];

  logic              accept, ret_ok, fifo_empty, byp_vld;
  logic              row_vld, pop_any, fifo_pop, fifo_push;
  logic [DATA_W-1:0] row_data;
  logic [ADDR_W-1:0] row_idx;
  logic [PW-1:0]     rd_idx, wr_idx;

  assign rd_idx = rd_ptr_q[PW-1:0];
  assign wr_idx = wr_ptr_q[PW-1:0];

  // Handshakes and the solver-side view of the FIFO head.
  always_comb begin
    accept     = rreq_q & i_mem_rrdy;
    ret_ok     = i_mem_dout_vld & (outst_q != '0);
    fifo_empty = (wr_ptr_q == rd_ptr_q);
`ifdef GSIM_FETCH_BYPASS_EN
    byp_vld    = fifo_empty & ret_ok;
`else
    byp_vld    = 1'b0;
`endif
    row_vld  = ~fifo_empty | byp_vld;
    row_data = '0;
    row_idx  = '0;
    if (!fifo_empty) begin
      row_data = fifo_data_q[rd_idx];
      row_idx  = fifo_idx_q[rd_idx];
    end else if (byp_vld) begin
      row_data = i_mem_dout;
      row_idx  = ret_cnt_q;
    end
    pop_any   = row_vld & i_row_rdy;
    fifo_pop  = pop_any & ~fifo_empty;
    // A bypassed row taken in the same cycle never enters the FIFO.
    fifo_push = ret_ok & ~(byp_vld & i_row_rdy);
  end

  // FIFO storage, pointers, outstanding-read counter, sticky error.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_idx_d  = fifo_idx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (fifo_push) begin
      fifo_data_d[wr_idx] = i_mem_dout;
      fifo_idx_d[wr_idx]  = ret_cnt_q;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    occ_d = wr_ptr_d - rd_ptr_d;

    outst_d = outst_q;
    if (accept && !ret_ok) begin
      outst_d = outst_q + 1'b1;
    end else if (!accept && ret_ok) begin
      outst_d = outst_q - 1'b1;
    end

    err_d = err_q | (i_mem_dout_vld & ~ret_ok);
  end

  // Burst control: state, address, counters and the registered request.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    req_cnt_d  = req_cnt_q;
    cons_cnt_d = cons_cnt_q;
    ret_cnt_d  = ret_cnt_q;

    if (accept) begin
      addr_d    = addr_q + 1'b1;
      req_cnt_d = req_cnt_q + 1'b1;
    end
    if (ret_ok) begin
      ret_cnt_d = ret_cnt_q + 1'b1;
    end
    if (pop_any) begin
      cons_cnt_d = cons_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          addr_d     = i_base_addr;
          len_d      = i_len;
          req_cnt_d  = '0;
          cons_cnt_d = '0;
          ret_cnt_d  = '0;
          state_d    = (i_len == '0) ? DONE : FETCH;
        end
      end
      FETCH: if (req_cnt_d == len_q) state_d = DRAIN;
      DRAIN: if (cons_cnt_d == len_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Request for next cycle is judged on post-update counts, so an
    // unaccepted request can never lose its credit and always holds.
    credit_used = {1'b0, outst_d} + {1'b0, occ_d};
    rreq_d      = (state_d == FETCH) && (credit_used < (PW+2)'(DEPTH));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      req_cnt_q   <= '0;
      cons_cnt_q  <= '0;
      ret_cnt_q   <= '0;
      outst_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rreq_q      <= 1'b0;
      err_q       <= 1'b0;
      fifo_data_q <= '{default: '0};
      fifo_idx_q  <= '{default: '0};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      req_cnt_q   <= req_cnt_d;
      cons_cnt_q  <= cons_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      outst_q     <= outst_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rreq_q      <= rreq_d;
      err_q       <= err_d;
      fifo_data_q <= fifo_data_d;
      fifo_idx_q  <= fifo_idx_d;
    end
  end

  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);
  assign o_mem_rreq = rreq_q;
  assign o_mem_addr = addr_q;
  assign o_row_vld  = row_vld;
  assign o_row_data = row_data;
  assign o_row_idx  = row_idx;
  assign o_err      = err_q;

endmodule

// File: tb/tb_gsim_row_fetch.sv
// Self-checking bench for gsim_row_fetch: a memory model with fixed latency
// answers requests from a random row image; a burst-level reference model
// (rows base+k in order, credit = requested - consumed) checks every cycle.
module tb_gsim_row_fetch;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 256;
`ifdef GSIM_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              i_clk;
  logic              i_rst_n;
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic [ADDR_W-1:0] i_len;
  logic              o_busy;
  logic              o_done;
  logic              o_mem_rreq;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_rrdy;
  logic [DATA_W-1:0] i_mem_dout;
  logic              i_mem_dout_vld;
  logic              o_row_vld;
  logic [DATA_W-1:0] o_row_data;
  logic [ADDR_W-1:0] o_row_idx;
  logic              i_row_rdy;
  logic              o_err;

  gsim_row_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_base_addr(i_base_addr), .i_len(i_len),
    .o_busy(o_busy), .o_done(o_done),
    .o_mem_rreq(o_mem_rreq), .o_mem_addr(o_mem_addr), .i_mem_rrdy(i_mem_rrdy),
    .i_mem_dout(i_mem_dout), .i_mem_dout_vld(i_mem_dout_vld),
    .o_row_vld(o_row_vld), .o_row_data(o_row_data), .o_row_idx(o_row_idx),
    .i_row_rdy(i_row_rdy), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [DATA_W-1:0] mem_img [1<<ADDR_W];
  int unsigned       pend_due[$];
  logic [ADDR_W-1:0] pend_addr[$];

  int unsigned checks, failures;
  int unsigned cyc, lat;
  int unsigned start_cyc, first_acc, last_acc, last_pop, done_cyc;
  int unsigned req_n, cons_n, ret_n, done_n, b_len, outst_m;
  logic [ADDR_W-1:0] b_base, prev_addr;
  bit seen_acc, prev_hold, busy_m, exp_err, exp_err_next, inj_stray;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pick(input int unsigned mode);
    case (mode)
      0: return 1'b1;
      1: return (cyc % 2 == 0);
      2: return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  // One clock: drive inputs at edge+1, sample at edge+2, advance the model.
  task automatic cycle_step(input bit rrdy, input bit rowrdy);
    bit legit, exp_vld, done_now;
    logic [ADDR_W-1:0] a;
    logic [31:0] r;
    i_mem_rrdy     = rrdy;
    i_row_rdy      = rowrdy;
    i_mem_dout_vld = 1'b0;
    i_mem_dout     = '0;
    legit          = 1'b0;
    done_now       = 1'b0;
    if (pend_due.size() != 0 && pend_due[0] == cyc) begin
      i_mem_dout_vld = 1'b1;
      i_mem_dout     = mem_img[pend_addr[0]];
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
      legit = (outst_m != 0);
    end else if (inj_stray) begin
      r = $urandom();
      i_mem_dout_vld = 1'b1;
      i_mem_dout     = {8{r}};
    end
    #1;
    chk("err", o_err, exp_err);
    chk("busy", o_busy, busy_m);
    exp_vld = (ret_n > cons_n) || (BYP && legit);
    chk("row_vld", o_row_vld, exp_vld);
    if (prev_hold) begin
      chk("req_hold", o_mem_rreq, 1'b1);
      chk("addr_hold", o_mem_addr, prev_addr);
    end
    if (o_mem_rreq) begin
      a = b_base + ADDR_W'(req_n);
      chk("req_addr", o_mem_addr, a);
      chk("req_in_len", req_n < b_len, 1'b1);
      chk("req_credit", (req_n - cons_n) < DEPTH, 1'b1);
    end
    if (o_row_vld) begin
      a = b_base + ADDR_W'(cons_n);
      chk("row_idx", o_row_idx, cons_n);
      chk("row_data", o_row_data, mem_img[a]);
    end
    if (i_mem_dout_vld) begin
      if (outst_m == 0) exp_err_next = 1'b1;
      else begin
        outst_m--;
        ret_n++;
      end
    end
    if (o_mem_rreq && rrdy) begin
      pend_due.push_back(cyc + lat);
      pend_addr.push_back(o_mem_addr);
      outst_m++;
      req_n++;
      if (!seen_acc) first_acc = cyc;
      seen_acc = 1'b1;
      last_acc = cyc;
    end
    if (o_row_vld && rowrdy) begin
      cons_n++;
      last_pop = cyc;
    end
    if (o_done) begin
      done_n++;
      done_cyc = cyc;
      done_now = 1'b1;
      chk("done_all_consumed", cons_n, b_len);
    end
    prev_hold = o_mem_rreq & ~rrdy;
    prev_addr = o_mem_addr;
    @(posedge i_clk);
    cyc++;
    #1;
    i_start = 1'b0;
    exp_err = exp_err_next;
    if (done_now) busy_m = 1'b0;
  endtask

  task automatic do_reset();
    i_rst_n        = 1'b0;
    i_start        = 1'b0;
    i_mem_dout_vld = 1'b0;
    inj_stray      = 1'b0;
    #1;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_rreq", o_mem_rreq, 1'b0);
    chk("rst_addr", o_mem_addr, '0);
    chk("rst_row_vld", o_row_vld, 1'b0);
    chk("rst_row_data", o_row_data, '0);
    chk("rst_row_idx", o_row_idx, '0);
    chk("rst_err", o_err, 1'b0);
    i_rst_n = 1'b1;
    outst_m = 0; exp_err = 1'b0; exp_err_next = 1'b0; busy_m = 1'b0;
    req_n = 0; cons_n = 0; ret_n = 0; done_n = 0; b_len = 0;
    prev_hold = 1'b0;
  endtask

  task automatic start_burst(input logic [ADDR_W-1:0] base, input int unsigned len,
                             input int unsigned rm, input int unsigned dm);
    i_start     = 1'b1;
    i_base_addr = base;
    i_len       = ADDR_W'(len);
    b_base = base; b_len = len;
    req_n = 0; cons_n = 0; ret_n = 0; done_n = 0; seen_acc = 1'b0;
    start_cyc = cyc;
    cycle_step(pick(rm), pick(dm));
    busy_m = 1'b1;
  endtask

  task automatic run_until_done(input int unsigned rm, input int unsigned dm,
                                input int unsigned bound, input int unsigned restart_at);
    int unsigned n = 0;
    while (done_n == 0 && n < bound) begin
      if (restart_at != 0 && n == restart_at) begin
        i_start     = 1'b1;
        i_base_addr = ADDR_W'($urandom());
        i_len       = ADDR_W'($urandom());
      end
      cycle_step(pick(rm), pick(dm));
      n++;
    end
    chk("burst_done_seen", done_n, 1);
    repeat (2) cycle_step(1'b1, 1'b1);
    chk("burst_single_done", done_n, 1);
  endtask

  initial begin
    logic [31:0] r;
    int unsigned blen;
    checks = 0; failures = 0; cyc = 0; lat = 2;
    i_rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_len = '0;
    i_mem_rrdy = 1'b0; i_mem_dout = '0; i_mem_dout_vld = 1'b0; i_row_rdy = 1'b0;
    inj_stray = 1'b0; busy_m = 1'b0; prev_hold = 1'b0;
    for (int unsigned i = 0; i < (1 << ADDR_W); i++)
      for (int unsigned w = 0; w < DATA_W / 32; w++) begin
        r = $urandom();
        mem_img[i][w*32 +: 32] = r;
      end
    repeat (3) @(posedge i_clk);
    #1;
    do_reset();

    // Base 17, 5 rows, latency 2, no stalls anywhere.
    start_burst(10'd17, 5, 0, 0);
    run_until_done(0, 0, 60, 0);
    chk("t1_first_req_lat", first_acc - start_cyc, 1);
    chk("t1_back_to_back", last_acc - first_acc, 4);
    chk("t1_done_after_pop", done_cyc - last_pop, 1);
    chk("t1_rows", cons_n, 5);

    // Solver stalled: only DEPTH requests may go out, then resume.
    start_burst(10'd100, 8, 0, 3);
    repeat (12) cycle_step(1'b1, 1'b0);
    chk("t2_req_cap", req_n, DEPTH);
    chk("t2_rreq_low", o_mem_rreq, 1'b0);
    run_until_done(0, 0, 80, 0);
    chk("t2_rows", cons_n, 8);

    // Memory ready toggling, burst wrapping past the top of the address space.
    start_burst(10'd1020, 9, 1, 0);
    run_until_done(1, 0, 100, 0);
    chk("t3_rows", cons_n, 9);

    // Zero-length burst.
    start_burst(10'd5, 0, 0, 0);
    run_until_done(0, 0, 4, 0);
    chk("t4_done_soon", (done_cyc - start_cyc) <= 2, 1'b1);
    chk("t4_no_req", req_n, 0);

    // Stray return while idle: sticky error, no row.
    inj_stray = 1'b1;
    cycle_step(1'b1, 1'b1);
    inj_stray = 1'b0;
    repeat (4) cycle_step(1'b1, 1'b1);
    chk("t5_err_sticky", o_err, 1'b1);
    do_reset();

    // Reset with three reads outstanding; late returns flag an error.
    lat = 3;
    start_burst(10'd200, 8, 0, 0);
    for (int unsigned n = 0; n < 10 && pend_due.size() != 3; n++) cycle_step(1'b1, 1'b1);
    chk("t6_three_pending", pend_due.size(), 3);
    do_reset();
    for (int unsigned n = 0; n < 8 && pend_due.size() != 0; n++) cycle_step(1'b1, 1'b1);
    chk("t6_late_err", o_err, 1'b1);
    lat = 2;
    start_burst(10'd0, 2, 0, 0);
    run_until_done(0, 0, 40, 0);
    chk("t6_rows", cons_n, 2);

    // Randomized bursts; the first also tries a restart while busy.
    do_reset();
    for (int unsigned k = 0; k < 6; k++) begin
      lat  = $urandom_range(1, 3);
      blen = (k == 0) ? 12 : $urandom_range(1, 20);
      start_burst(ADDR_W'($urandom()), blen, $urandom_range(0, 2), $urandom_range(0, 2));
      run_until_done($urandom_range(0, 2), $urandom_range(0, 2), 400, (k == 0) ? 2 : 0);
      chk("t7_rows", cons_n, blen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
